// File: rtl/round_sequencer.sv
// Memory-game scheduler: grows an LFSR-driven note sequence one note per round,
// plays it back on the LEDs, then checks the player's key presses against it.
module round_sequencer #(
  parameter int          MAX_NOTES   = 4,
  parameter int          NOTE_PERIOD = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] key_in,
  output logic [3:0] note_out,
  output logic [3:0] state_out,
  output logic [3:0] score,
  output logic       won,
  output logic       lost
);

  localparam int SW = 4 * MAX_NOTES;
  localparam int TW = (NOTE_PERIOD > 1) ? $clog2(NOTE_PERIOD) : 1;
  localparam logic [TW-1:0] TRELOAD = TW'(NOTE_PERIOD - 1);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] NEW_NOTE = 4'd1;
  localparam logic [3:0] PLAY_ON  = 4'd2;
  localparam logic [3:0] PLAY_GAP = 4'd3;
  localparam logic [3:0] WAIT_KEY = 4'd4;
  localparam logic [3:0] CHECK    = 4'd5;
  localparam logic [3:0] WAIT_REL = 4'd6;
  localparam logic [3:0] ROUND_OK = 4'd7;
  localparam logic [3:0] WON      = 4'd8;
  localparam logic [3:0] LOST     = 4'd9;

  logic [3:0]    state_q, state_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    score_q, score_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [3:0]    key_prev_q;
  logic [3:0]    pressed_q, pressed_d;
  logic [SW-1:0] seq_q, seq_d;

  logic [3:0] cur_note;
  logic [3:0] new_oh;
  logic       press_ev;
  logic       last_note;

  always_comb begin
    cur_note = 4'd0;
    for (int i = 0; i < MAX_NOTES; i++)
      if (idx_q == 4'(i)) cur_note = seq_q[4*i +: 4];
  end

  assign new_oh    = 4'b0001 << lfsr_q[1:0];
  // A press is only the 0 -> nonzero transition, so a key held across states is ignored.
  assign press_ev  = (key_prev_q == 4'd0) && (key_in != 4'd0);
  assign last_note = (idx_q == len_q - 4'd1);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    score_d   = score_q;
    timer_d   = timer_q;
    lfsr_d    = lfsr_q;
    pressed_d = pressed_q;
    seq_d     = seq_q;
    case (state_q)
      IDLE, WON, LOST: begin
        if (start) begin
          len_d   = 4'd0;
          score_d = 4'd0;
          state_d = NEW_NOTE;
        end
      end
      NEW_NOTE: begin
        for (int i = 0; i < MAX_NOTES; i++)
          if (len_q == 4'(i)) seq_d[4*i +: 4] = new_oh;
        lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        len_d   = len_q + 4'd1;
        idx_d   = 4'd0;
        timer_d = TRELOAD;
        state_d = PLAY_ON;
      end
      PLAY_ON: begin
        if (timer_q == '0) begin
          timer_d = TRELOAD;
          state_d = PLAY_GAP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      PLAY_GAP: begin
        if (timer_q == '0) begin
          if (last_note) begin
            idx_d   = 4'd0;
            state_d = WAIT_KEY;
          end else begin
            idx_d   = idx_q + 4'd1;
            timer_d = TRELOAD;
            state_d = PLAY_ON;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      WAIT_KEY: begin
        if (press_ev) begin
          pressed_d = key_in;
          state_d   = CHECK;
        end
      end
      CHECK: state_d = (pressed_q == cur_note) ? WAIT_REL : LOST;
      WAIT_REL: begin
        if (key_in == 4'd0) begin
          if (last_note) begin
            state_d = ROUND_OK;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = WAIT_KEY;
          end
        end
      end
      ROUND_OK: begin
        score_d = score_q + 4'd1;
        state_d = (len_q == 4'(MAX_NOTES)) ? WON : NEW_NOTE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= 4'd0;
      idx_q      <= 4'd0;
      score_q    <= 4'd0;
      timer_q    <= '0;
      lfsr_q     <= LFSR_SEED;
      key_prev_q <= 4'd0;
      pressed_q  <= 4'd0;
      seq_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      score_q    <= score_d;
      timer_q    <= timer_d;
      lfsr_q     <= lfsr_d;
      key_prev_q <= key_in;
      pressed_q  <= pressed_d;
      seq_q      <= seq_d;
    end
  end

  always_comb begin
    case (state_q)
      PLAY_ON:                     note_out = cur_note;
      NEW_NOTE, PLAY_GAP, ROUND_OK: note_out = 4'd0;
      default:                     note_out = key_in;
    endcase
  end

  assign state_out = state_q;
  assign score     = score_q;
  assign won       = (state_q == WON);
  assign lost      = (state_q == LOST);

endmodule
